// File: rtl/vga_pkg.sv
// Shared VGA definitions: colour constants, 1024x768 timing constants,
// and the small types used by the bouncing-box renderer.
package vga_pkg;

    // 24-bit {R,G,B} colour constants
    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] ORANGE = 24'hFFA500;
    localparam logic [23:0] YELLOW = 24'hFFFF00;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] CYAN   = 24'h00FFFF;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] PURPLE = 24'hA020F0;
    localparam logic [23:0] BLACK  = 24'h000000;

    // 1024x768 @ 60 Hz timing, shared with the timing generator
    localparam int   VGA_H_ACTIVE = 1024;
    localparam int   VGA_H_FP     = 24;
    localparam int   VGA_H_SYNC   = 136;
    localparam int   VGA_H_BP     = 160;
    localparam int   VGA_V_ACTIVE = 768;
    localparam int   VGA_V_FP     = 3;
    localparam int   VGA_V_SYNC   = 6;
    localparam int   VGA_V_BP     = 29;
    localparam logic VGA_HS_POL   = 1'b0;
    localparam logic VGA_VS_POL   = 1'b0;

    // Datapath widths
    localparam int COORD_W = 12;
    localparam int CMP_W   = 13;  // one guard bit so pos + SIZE + STEP cannot overflow
    localparam int CNT_W   = 16;

    // Box travel direction along one axis
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

endpackage

// File: rtl/bouncing_box_renderer_if.sv
// Pixel bus between the VGA timing generator, the renderer and the pins,
// plus the renderer's box state outputs.
interface bouncing_box_renderer_if;
    import vga_pkg::*;

    logic               in_hs;
    logic               in_vs;
    logic               in_de;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic               pause;
    logic               out_hs;
    logic               out_vs;
    logic               out_de;
    logic [7:0]         out_r;
    logic [7:0]         out_g;
    logic [7:0]         out_b;
    logic [COORD_W-1:0] box_x;
    logic [COORD_W-1:0] box_y;
    logic [CNT_W-1:0]   frame_count;
    logic               dir_x;        // 1 = box moving left
    logic               dir_y;        // 1 = box moving up

    // Upstream side: drives timing/coordinates, observes rendered pixels
    modport master (
        output in_hs, in_vs, in_de, in_x, in_y, pause,
        input  out_hs, out_vs, out_de, out_r, out_g, out_b,
               box_x, box_y, frame_count, dir_x, dir_y
    );

    // Renderer side
    modport slave (
        input  in_hs, in_vs, in_de, in_x, in_y, pause,
        output out_hs, out_vs, out_de, out_r, out_g, out_b,
               box_x, box_y, frame_count, dir_x, dir_y
    );

endinterface

// File: rtl/bouncing_box_renderer_axis.sv
// One axis of box motion: steps pos by STEP per enable and reflects off
// 0 and LIMIT-SIZE, clamping to the edge on the bounce frame.
module bounce_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 1024,
    parameter int SIZE  = 100,
    parameter int STEP  = 2,
    parameter int INIT  = 270
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    output logic [COORD_W-1:0] pos,
    output dir_e               dir
);

    localparam logic [CMP_W-1:0]   MAX_POS   = CMP_W'(LIMIT - SIZE);
    localparam logic [CMP_W-1:0]   LIMIT_W   = CMP_W'(LIMIT);
    localparam logic [CMP_W-1:0]   REACH_W   = CMP_W'(SIZE + STEP);
    localparam logic [CMP_W-1:0]   STEP_W    = CMP_W'(STEP);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] MAX_POS_C = MAX_POS[COORD_W-1:0];

    logic [COORD_W-1:0] pos_q, pos_d;
    dir_e               dir_q, dir_d;
    logic [CMP_W-1:0]   pos_w;

    assign pos_w = {1'b0, pos_q};

    // Next position/direction: move one step, or clamp and reverse at an edge
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_en) begin
            if (dir_q == DIR_POS) begin
                if (pos_w + REACH_W >= LIMIT_W) begin
                    pos_d = MAX_POS_C;
                    dir_d = DIR_NEG;
                end else begin
                    pos_d = pos_q + STEP_C;
                end
            end else begin
                if (pos_w <= STEP_W) begin
                    pos_d = '0;
                    dir_d = DIR_POS;
                end else begin
                    pos_d = pos_q - STEP_C;
                end
            end
        end
    end

    // Position/direction state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= COORD_W'(INIT);
            dir_q <= DIR_POS;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos = pos_q;
    assign dir = dir_q;

endmodule

// File: rtl/bouncing_box_renderer.sv
// Pixel-stage renderer: paints a bouncing solid square on black and
// re-times sync/data-enable by one cycle so they stay aligned with RGB.
module bouncing_box_renderer
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = VGA_H_ACTIVE,
    parameter int          V_ACTIVE = VGA_V_ACTIVE,
    parameter int          BOX_SIZE = 100,
    parameter int          STEP     = 2,
    parameter int          INIT_X   = 270,
    parameter int          INIT_Y   = 190,
    parameter logic [23:0] BOX_RGB  = PURPLE,
    parameter logic        HS_POL   = VGA_HS_POL,
    parameter logic        VS_POL   = VGA_VS_POL
) (
    input logic                   clk,
    input logic                   rst,
    bouncing_box_renderer_if.slave bus
);

    localparam logic [CMP_W-1:0] SIZE_W = CMP_W'(BOX_SIZE);

    logic               vs_q;
    logic               armed_q;
    logic               fs;
    logic               step_en;
    logic               hs_q, vs_out_q, de_q;
    logic [23:0]        rgb_q, rgb_d;
    logic [CNT_W-1:0]   fc_q, fc_d;
    logic [COORD_W-1:0] box_x, box_y;
    dir_e               dir_x, dir_y;
    logic               in_box;

    // Frame start: in_vs entering its active level. The first cycle after
    // reset only primes the history, so a vs already active at release is ignored.
    assign fs      = armed_q && (bus.in_vs == VS_POL) && (vs_q != VS_POL);
    assign step_en = fs && !bus.pause;

    // vs history and post-reset arming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q    <= ~VS_POL;
            armed_q <= 1'b0;
        end else begin
            vs_q    <= bus.in_vs;
            armed_q <= 1'b1;
        end
    end

    bounce_axis #(
        .LIMIT (H_ACTIVE),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP),
        .INIT  (INIT_X)
    ) u_axis_x (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .pos     (box_x),
        .dir     (dir_x)
    );

    bounce_axis #(
        .LIMIT (V_ACTIVE),
        .SIZE  (BOX_SIZE),
        .STEP  (STEP),
        .INIT  (INIT_Y)
    ) u_axis_y (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .pos     (box_y),
        .dir     (dir_y)
    );

    // Box hit test on the incoming pixel, 13 bits wide so box + SIZE cannot wrap
    always_comb begin
        in_box = bus.in_de
              && ({1'b0, bus.in_x} >= {1'b0, box_x})
              && ({1'b0, bus.in_x} <  {1'b0, box_x} + SIZE_W)
              && ({1'b0, bus.in_y} >= {1'b0, box_y})
              && ({1'b0, bus.in_y} <  {1'b0, box_y} + SIZE_W);
        rgb_d  = in_box ? BOX_RGB : BLACK;
        fc_d   = fs ? fc_q + CNT_W'(1) : fc_q;
    end

    // Output stage: sync, data-enable and colour all delayed by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q     <= ~HS_POL;
            vs_out_q <= ~VS_POL;
            de_q     <= 1'b0;
            rgb_q    <= BLACK;
        end else begin
            hs_q     <= bus.in_hs;
            vs_out_q <= bus.in_vs;
            de_q     <= bus.in_de;
            rgb_q    <= rgb_d;
        end
    end

    // Frame counter, counts every frame start including paused ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign bus.out_hs      = hs_q;
    assign bus.out_vs      = vs_out_q;
    assign bus.out_de      = de_q;
    assign bus.out_r       = rgb_q[23:16];
    assign bus.out_g       = rgb_q[15:8];
    assign bus.out_b       = rgb_q[7:0];
    assign bus.box_x       = box_x;
    assign bus.box_y       = box_y;
    assign bus.frame_count = fc_q;
    assign bus.dir_x       = (dir_x == DIR_NEG);
    assign bus.dir_y       = (dir_y == DIR_NEG);

endmodule

// File: doc/bouncing_box_renderer.md
# bouncing_box_renderer

Pixel-stage renderer that sits directly downstream of the VGA timing generator and upstream of the VGA output pins. It consumes the generator's sync, data-enable and active-area pixel coordinates, and paints a solid square on a black background. The square moves a fixed step each frame and bounces off the active-area edges. Sync and data-enable are re-registered so they stay cycle-aligned with the RGB data.

## Interface
Parameters:
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- BOX_SIZE, 100, square edge length in pixels (BOX_SIZE < H_ACTIVE, BOX_SIZE < V_ACTIVE)
- STEP, 2, pixels moved per frame on each axis (STEP < BOX_SIZE)
- INIT_X, 270, box left edge after reset
- INIT_Y, 190, box top edge after reset
- BOX_RGB, 24'hA020F0, box colour as {R,G,B}
- HS_POL, 1'b0, active level of in_hs / out_hs
- VS_POL, 1'b0, active level of in_vs / out_vs

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous, active-high
- in_hs  in  1  horizontal sync from the timing generator
- in_vs  in  1  vertical sync from the timing generator
- in_de  in  1  active-video flag from the timing generator
- in_x  in  12  active-area column, 0 = leftmost; valid only while in_de=1
- in_y  in  12  active-area row, 0 = top; valid only while in_de=1
- pause  in  1  1 = freeze box position
- out_hs  out  1  in_hs delayed 1 cycle
- out_vs  out  1  in_vs delayed 1 cycle
- out_de  out  1  in_de delayed 1 cycle
- out_r, out_g, out_b  out  8 each  pixel colour
- box_x  out  12  current box left edge
- box_y  out  12  current box top edge
- frame_count  out  16  count of frame starts since reset; wraps 0xFFFF -> 0

## Operation
- Frame start (fs) is a one-cycle internal pulse. It fires on the cycle in which in_vs changes from ~VS_POL to VS_POL. Detection uses a registered copy of in_vs.
- On fs:
  - frame_count increments.
  - If pause=0, each axis updates as described below.
  - If pause=1, position and direction hold; frame_count still increments.
- Per-axis update, with LIMIT = H_ACTIVE (x) or V_ACTIVE (y) and dir reset to +:
  - dir + and pos + BOX_SIZE + STEP >= LIMIT: pos <= LIMIT - BOX_SIZE, dir <= -.
  - dir +, otherwise: pos <= pos + STEP.
  - dir - and pos <= STEP: pos <= 0, dir <= +.
  - dir -, otherwise: pos <= pos - STEP.
- Width rules: all comparisons are computed 13 bits wide, so the sum cannot overflow. pos is always within [0, LIMIT - BOX_SIZE].
- The x and y axes update independently. A corner hit flips both directions in the same fs.
- Colour, registered:
  - If in_de=1 and box_x <= in_x < box_x + BOX_SIZE and box_y <= in_y < box_y + BOX_SIZE, output BOX_RGB.
  - Otherwise output 0,0,0. This includes every cycle with in_de=0, whatever in_x/in_y hold.
- Position only changes at fs, which occurs in vertical blanking. A frame therefore never shows a mix of old and new positions.

## Timing
- Latency: out_hs, out_vs, out_de and out_r/g/b all lag their inputs by exactly 1 clk.
- Position: box_x/box_y/frame_count update on the clock edge that follows the cycle in which fs is asserted. In-frame pixels always see the stable value.
- Reset values:
  - out_hs = ~HS_POL, out_vs = ~VS_POL, out_de = 0, RGB = 0.
  - box_x = INIT_X, box_y = INIT_Y, both dir = +, frame_count = 0.
  - The vs history register resets to ~VS_POL.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously).
- After reset release, the first fs moves the box. A vs already held at VS_POL when reset releases does not produce an fs.
- A pause change takes effect at the next fs. pause is sampled only while fs is asserted.

## Structure
- Shared package vga_pkg:
  - colour constants (WHITE, RED, ORANGE, YELLOW, GREEN, CYAN, BLUE, PURPLE, BLACK as 24-bit values);
  - 1024x768 timing constants (active, porch and sync widths, polarities), shared with the timing generator.
- Sub-module bounce_axis, instantiated twice (x, y):
  - ports: clk, rst, step_en, pos, dir;
  - parameters: LIMIT, SIZE, STEP, INIT.

## Test plan
- Reset, then drive in_de=1, in_x=270, in_y=190 -> next cycle RGB = A0,20,F0. Then in_x=370 -> black. Then in_x=369, in_y=289 -> purple.
- in_de=0 with in_x=300, in_y=200 -> RGB = 0 and out_de=0, one cycle later.
- One vs falling edge with default parameters -> box_x=272, box_y=192, frame_count=1.
- INIT_X=923: first fs -> box_x=924, dir -. Second fs -> box_x=922.
- Drive the box left with INIT_X=4 after a forced right bounce, until pos=2. Next fs -> box_x=0, dir +. Following fs -> box_x=2.
- pause=1 across 3 fs -> box_x/box_y unchanged, frame_count +3. Assert rst mid-line -> every output returns to its reset value in the same cycle.
